// File: rtl/pkt_readout_pkg.sv
// Shared state encoding and datapath widths for the FPGA -> EZ-USB readout sequencer.
package pkt_readout_pkg;

   localparam int SUBWORDS = 8;
   localparam int WORD_W   = 16;
   localparam int FIFO_W   = 128;
   localparam int SUB_W    = $clog2(SUBWORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_ARM,
      ST_RELEASE
   } state_e;

endpackage

// File: rtl/pkt_word_serializer.sv
// Holds one 128-bit FIFO word and presents it as 16-bit subwords, LSB word first.
module pkt_word_serializer
   import pkt_readout_pkg::*;
(
   input  logic              ifclk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [FIFO_W-1:0] data_i,
   output logic [WORD_W-1:0] word_o,
   output logic [SUB_W-1:0]  sub_o
);

   logic [FIFO_W-1:0] buf_q, buf_d;
   logic [SUB_W-1:0]  sub_q, sub_d;

   // A load always restarts at subword 0, so it takes priority over advance.
   always_comb begin
      buf_d = buf_q;
      sub_d = sub_q;
      if (load_i) begin
         buf_d = data_i;
         sub_d = '0;
      end else if (advance_i) begin
         sub_d = sub_q + SUB_W'(1);
      end
   end

   // NOTE: buf_q is a plain register, not a RAM, so it is reset; that is what makes usb_di read 0 out of reset.
   always_ff @(posedge ifclk) begin
      if (!reset_n) begin
         buf_q <= '0;
         sub_q <= '0;
      end else begin
         buf_q <= buf_d;
         sub_q <= sub_d;
      end
   end

   assign word_o = buf_q[WORD_W*sub_q +: WORD_W];
   assign sub_o  = sub_q;

endmodule

// File: rtl/pkt_readout_ctrl.sv
// Readout sequencer: FWFT FIFO -> 16-bit USB words, cut into packets closed with PKTEND.
// Optional PKTEND watchdog enabled by defining PKT_READOUT_TIMEOUT_EN.
module pkt_readout_ctrl
   import pkt_readout_pkg::*;
#(
   parameter int PKTEND_TIMEOUT = 65535
)(
   input  logic              ifclk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [15:0]       pkt_len,
   input  logic [FIFO_W-1:0] fifo_do,
   input  logic              fifo_empty,
   output logic              fifo_rden,
   output logic [WORD_W-1:0] usb_di,
   output logic              usb_di_valid,
   input  logic              usb_di_ready,
   output logic              pktend_arm,
   input  logic              pktend_n,
   output logic [15:0]       pkt_count,
   output logic              busy,
   output logic              tmo_err
);

   if (PKTEND_TIMEOUT < 1 || PKTEND_TIMEOUT > 65535) begin : g_bad_timeout
      $error("PKTEND_TIMEOUT must be within 1..65535");
   end

   state_e           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [15:0]      wcnt_q, wcnt_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             paused_q, paused_d;
   logic             ser_load, ser_adv;
   logic [SUB_W-1:0] sub;
   logic             xfer, pkt_end, tmo_hit;

   pkt_word_serializer u_ser (
      .ifclk     (ifclk),
      .reset_n   (reset_n),
      .load_i    (ser_load),
      .advance_i (ser_adv),
      .data_i    (fifo_do),
      .word_o    (usb_di),
      .sub_o     (sub)
   );

   assign xfer    = (state_q == ST_SEND) && !paused_q && usb_di_ready;
   assign pkt_end = xfer && (len_q != 16'd0) && (wcnt_q + 16'd1 == len_q);

`ifdef PKT_READOUT_TIMEOUT_EN
   localparam logic [15:0] TMO_LIMIT = 16'(PKTEND_TIMEOUT);
   logic [15:0] wdog_q;
   logic        tmo_err_q;

   // Fires on the PKTEND_TIMEOUT-th consecutive ARM cycle.
   assign tmo_hit = (state_q == ST_ARM) && (wdog_q + 16'd1 == TMO_LIMIT);

   always_ff @(posedge ifclk) begin
      if (!reset_n) begin
         wdog_q    <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         wdog_q <= (state_q == ST_ARM) ? wdog_q + 16'd1 : 16'd0;
         if (tmo_hit) tmo_err_q <= 1'b1;
      end
   end

   assign tmo_err = tmo_err_q;
`else
   assign tmo_hit = 1'b0;
   assign tmo_err = 1'b0;
`endif

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wcnt_d    = wcnt_q;
      cnt_d     = cnt_q;
      paused_d  = paused_q;
      ser_load  = 1'b0;
      ser_adv   = 1'b0;
      fifo_rden = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty) begin
               len_d   = pkt_len;
               wcnt_d  = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!fifo_empty) begin
               fifo_rden = 1'b1;
               ser_load  = 1'b1;
               paused_d  = 1'b0;
               state_d   = ST_SEND;
            end else if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (paused_q) begin
               if (enable) paused_d = 1'b0;
            end else if (xfer) begin
               ser_adv = 1'b1;
               wcnt_d  = wcnt_q + 16'd1;
               if (pkt_end) begin
                  state_d = ST_ARM;
               end else if (sub == SUB_W'(SUBWORDS - 1)) begin
                  if (!fifo_empty) begin
                     fifo_rden = 1'b1;
                     ser_load  = 1'b1;
                     paused_d  = !enable;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end else begin
                  // A pause only takes hold once the pending word has been accepted.
                  paused_d = !enable;
               end
            end
         end
         ST_ARM: begin
            if (!pktend_n || tmo_hit) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            cnt_d    = cnt_q + 16'd1;
            wcnt_d   = '0;
            len_d    = pkt_len;
            paused_d = 1'b0;
            state_d  = (sub != '0) ? ST_SEND : ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ifclk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         wcnt_q   <= '0;
         cnt_q    <= '0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         wcnt_q   <= wcnt_d;
         cnt_q    <= cnt_d;
         paused_q <= paused_d;
      end
   end

   assign usb_di_valid = (state_q == ST_SEND) && !paused_q;
   assign pktend_arm   = (state_q == ST_ARM);
   assign busy         = (state_q != ST_IDLE);
   assign pkt_count    = cnt_q;

endmodule

// File: tb/tb_pkt_readout_ctrl.sv
// Directed testbench for pkt_readout_ctrl; FIFO and USB sink are modelled in the bench.
module tb_pkt_readout_ctrl;

   localparam int TMO = 10;

   logic         ifclk        = 1'b0;
   logic         reset_n      = 1'b0;
   logic         enable       = 1'b0;
   logic [15:0]  pkt_len      = 16'd0;
   logic [127:0] fifo_do;
   logic         fifo_empty;
   logic         fifo_rden;
   logic [15:0]  usb_di;
   logic         usb_di_valid;
   logic         usb_di_ready = 1'b0;
   logic         pktend_arm;
   logic         pktend_n     = 1'b1;
   logic [15:0]  pkt_count;
   logic         busy;
   logic         tmo_err;

   int n_vec  = 0;
   int n_miss = 0;

   pkt_readout_ctrl #(.PKTEND_TIMEOUT(TMO)) dut (
      .ifclk        (ifclk),
      .reset_n      (reset_n),
      .enable       (enable),
      .pkt_len      (pkt_len),
      .fifo_do      (fifo_do),
      .fifo_empty   (fifo_empty),
      .fifo_rden    (fifo_rden),
      .usb_di       (usb_di),
      .usb_di_valid (usb_di_valid),
      .usb_di_ready (usb_di_ready),
      .pktend_arm   (pktend_arm),
      .pktend_n     (pktend_n),
      .pkt_count    (pkt_count),
      .busy         (busy),
      .tmo_err      (tmo_err)
   );

   always #5 ifclk = ~ifclk;

   // FWFT FIFO model: bench pushes, DUT pops on fifo_rden.
   logic [127:0] fifo_mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops   = 0;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_do    = fifo_mem[rd_ptr[5:0]];

   always @(posedge ifclk) begin
      if (fifo_rden) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
   end

   // USB-side monitor: inputs settle at the falling edge, the handshake happens at the next rising edge.
   logic [15:0] rx_q [$];
   int          rx_pops [$];
   int          rx_cyc [$];
   int          cyc        = 0;
   int          arm_cycles = 0;

   always @(negedge ifclk) begin
      #1;
      cyc = cyc + 1;
      if (reset_n && usb_di_valid && usb_di_ready) begin
         rx_q.push_back(usb_di);
         rx_pops.push_back(pops);
         rx_cyc.push_back(cyc);
      end
      if (pktend_arm) arm_cycles = arm_cycles + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge ifclk);
   endtask

   task automatic push_word(input logic [15:0] base);
      logic [127:0] w;
      for (int i = 0; i < 8; i++) w[16*i +: 16] = base + 16'(i);
      fifo_mem[wr_ptr[5:0]] = w;
      wr_ptr++;
   endtask

   task automatic do_reset();
      @(negedge ifclk);
      reset_n      = 1'b0;
      enable       = 1'b0;
      usb_di_ready = 1'b0;
      pktend_n     = 1'b1;
      tick(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_rx(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (rx_q.size() >= target) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic wait_arm(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (pktend_arm) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (usb_di_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic pulse_pktend();
      pktend_n = 1'b0;
      tick(1);
      pktend_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      tick(3);
      n_vec++;
      if ({busy, usb_di_valid, pktend_arm, fifo_rden, tmo_err} !== 5'b0) begin
         n_miss++;
         $display("FAIL reset_ctl: busy/valid/arm/rden/tmo=%b expected 00000",
                  {busy, usb_di_valid, pktend_arm, fifo_rden, tmo_err});
      end
      reset_n = 1'b1;
      tick(1);
      n_vec++;
      if (pkt_count !== 16'd0 || usb_di !== 16'd0) begin
         n_miss++;
         $display("FAIL reset_data: pkt_count=%0h usb_di=%0h expected 0 0", pkt_count, usb_di);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_idle: busy=%b expected 0 with enable low", busy);
      end
   endtask

   task automatic test_streaming();
      int b0, p0, a0;
      bit ok;
      do_reset();
      b0 = rx_q.size(); p0 = pops; a0 = arm_cycles;
      pkt_len = 16'd0;
      push_word(16'h0000);
      push_word(16'h0008);
      usb_di_ready = 1'b1;
      enable       = 1'b1;
      tick(1);
      n_vec++;
      if ({fifo_rden, busy, usb_di_valid} !== 3'b110) begin
         n_miss++;
         $display("FAIL stream_load: rden/busy/valid=%b expected 110", {fifo_rden, busy, usb_di_valid});
      end
      tick(1);
      n_vec++;
      if (usb_di_valid !== 1'b1 || usb_di !== 16'd0) begin
         n_miss++;
         $display("FAIL stream_first: valid=%b usb_di=%0h expected 1 0", usb_di_valid, usb_di);
      end
      wait_rx(b0 + 16, 40, ok);
      tick(3);
      n_vec++;
      if (!ok || rx_q.size() != b0 + 16) begin
         n_miss++;
         $display("FAIL stream_count: got %0d words expected 16", rx_q.size() - b0);
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (rx_q[b0+i] !== 16'(i)) begin
               n_miss++;
               $display("FAIL stream_word%0d: got %0h expected %0h", i, rx_q[b0+i], i);
            end
         end
         n_vec++;
         if (rx_cyc[b0+15] - rx_cyc[b0] != 15) begin
            n_miss++;
            $display("FAIL stream_gap: span %0d cycles expected 15", rx_cyc[b0+15] - rx_cyc[b0]);
         end
      end
      n_vec++;
      if (pops - p0 != 2 || arm_cycles != a0) begin
         n_miss++;
         $display("FAIL stream_pops_arm: pops=%0d arm_cycles=%0d expected 2 0", pops - p0, arm_cycles - a0);
      end
      enable = 1'b0;
      tick(2);
      n_vec++;
      if (busy !== 1'b0) begin
         n_miss++;
         $display("FAIL stream_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_split_packet();
      int b0, p0;
      bit ok;
      do_reset();
      b0 = rx_q.size(); p0 = pops;
      pkt_len = 16'd12;
      push_word(16'h0100);
      push_word(16'h0108);
      push_word(16'h0110);
      usb_di_ready = 1'b1;
      enable       = 1'b1;
      wait_arm(60, ok);
      n_vec++;
      if (!ok || rx_q.size() - b0 != 12 || pkt_count !== 16'd0 || pops - p0 != 2) begin
         n_miss++;
         $display("FAIL split_arm1: arm=%b words=%0d pkt_count=%0d pops=%0d expected 1 12 0 2",
                  ok, rx_q.size() - b0, pkt_count, pops - p0);
      end
      pulse_pktend();
      n_vec++;
      if (pkt_count !== 16'd1 || usb_di_valid !== 1'b1 || usb_di !== 16'h010C) begin
         n_miss++;
         $display("FAIL split_release: pkt_count=%0d valid=%b usb_di=%0h expected 1 1 10c",
                  pkt_count, usb_di_valid, usb_di);
      end
      wait_arm(60, ok);
      n_vec++;
      if (!ok || rx_q.size() - b0 != 24 || pops - p0 != 3) begin
         n_miss++;
         $display("FAIL split_arm2: arm=%b words=%0d pops=%0d expected 1 24 3", ok, rx_q.size() - b0, pops - p0);
      end else begin
         n_vec++;
         if (rx_pops[b0+15] - p0 != 2) begin
            n_miss++;
            $display("FAIL split_nopop: pops before word 15 = %0d expected 2", rx_pops[b0+15] - p0);
         end
         for (int i = 0; i < 24; i++) begin
            n_vec++;
            if (rx_q[b0+i] !== 16'h0100 + 16'(i)) begin
               n_miss++;
               $display("FAIL split_word%0d: got %0h expected %0h", i, rx_q[b0+i], 16'h0100 + 16'(i));
            end
         end
      end
      pulse_pktend();
      n_vec++;
      if (pkt_count !== 16'd2) begin
         n_miss++;
         $display("FAIL split_count2: pkt_count=%0d expected 2", pkt_count);
      end
      enable = 1'b0;
      tick(3);
   endtask

   task automatic test_backpressure();
      int b0;
      bit ok;
      do_reset();
      b0 = rx_q.size();
      pkt_len = 16'd0;
      push_word(16'h0200);
      usb_di_ready = 1'b0;
      enable       = 1'b1;
      wait_valid(10, ok);
      n_vec++;
      if (!ok || usb_di !== 16'h0200) begin
         n_miss++;
         $display("FAIL bp_first: valid=%b usb_di=%0h expected 1 200", ok, usb_di);
      end
      usb_di_ready = 1'b1;
      tick(1);
      for (int s = 0; s < 3; s++) begin
         usb_di_ready = (s == 2);
         n_vec++;
         if (usb_di_valid !== 1'b1 || usb_di !== 16'h0201) begin
            n_miss++;
            $display("FAIL bp_hold%0d: valid=%b usb_di=%0h expected 1 201", s, usb_di_valid, usb_di);
         end
         if (s != 2) tick(1);
      end
      wait_rx(b0 + 8, 30, ok);
      tick(2);
      n_vec++;
      if (!ok || rx_q.size() - b0 != 8) begin
         n_miss++;
         $display("FAIL bp_count: got %0d words expected 8", rx_q.size() - b0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (rx_q[b0+i] !== 16'h0200 + 16'(i)) begin
               n_miss++;
               $display("FAIL bp_word%0d: got %0h expected %0h", i, rx_q[b0+i], 16'h0200 + 16'(i));
            end
         end
      end
      enable = 1'b0;
      tick(3);
   endtask

   task automatic test_pause();
      int b0;
      bit ok;
      do_reset();
      b0 = rx_q.size();
      pkt_len = 16'd0;
      push_word(16'h0300);
      push_word(16'h0308);
      usb_di_ready = 1'b0;
      enable       = 1'b1;
      wait_valid(10, ok);
      enable = 1'b0;
      tick(1);
      n_vec++;
      if (!ok || usb_di_valid !== 1'b1 || usb_di !== 16'h0300) begin
         n_miss++;
         $display("FAIL pause_hold: valid=%b usb_di=%0h expected 1 300", usb_di_valid, usb_di);
      end
      usb_di_ready = 1'b1;
      tick(1);
      n_vec++;
      if (usb_di_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL pause_drop: valid=%b expected 0", usb_di_valid);
      end
      tick(2);
      n_vec++;
      if (usb_di_valid !== 1'b0 || rx_q.size() - b0 != 1) begin
         n_miss++;
         $display("FAIL pause_stay: valid=%b words=%0d expected 0 1", usb_di_valid, rx_q.size() - b0);
      end
      enable = 1'b1;
      tick(1);
      n_vec++;
      if (usb_di_valid !== 1'b1 || usb_di !== 16'h0301) begin
         n_miss++;
         $display("FAIL pause_resume: valid=%b usb_di=%0h expected 1 301", usb_di_valid, usb_di);
      end
      wait_rx(b0 + 16, 40, ok);
      tick(2);
      n_vec++;
      if (!ok || rx_q.size() - b0 != 16) begin
         n_miss++;
         $display("FAIL pause_count: got %0d words expected 16", rx_q.size() - b0);
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (rx_q[b0+i] !== 16'h0300 + 16'(i)) begin
               n_miss++;
               $display("FAIL pause_word%0d: got %0h expected %0h", i, rx_q[b0+i], 16'h0300 + 16'(i));
            end
         end
      end
      enable = 1'b0;
      tick(3);
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      do_reset();
      pkt_len = 16'd4;
      push_word(16'h0400);
      usb_di_ready = 1'b1;
      enable       = 1'b1;
      pktend_n     = 1'b1;
      wait_arm(30, ok);
      n_vec++;
      if (!ok) begin
         n_miss++;
         $display("FAIL tmo_arm: pktend_arm=%b expected 1", pktend_arm);
      end
      n = 0;
`ifdef PKT_READOUT_TIMEOUT_EN
      while (pktend_arm && n < 200) begin
         n++;
         tick(1);
      end
      n_vec++;
      if (n != TMO || tmo_err !== 1'b1) begin
         n_miss++;
         $display("FAIL tmo_fire: arm cycles=%0d tmo_err=%b expected %0d 1", n, tmo_err, TMO);
      end
      tick(1);
      n_vec++;
      if (pkt_count !== 16'd1) begin
         n_miss++;
         $display("FAIL tmo_count: pkt_count=%0d expected 1", pkt_count);
      end
`else
      while (pktend_arm && n < 30) begin
         n++;
         tick(1);
      end
      n_vec++;
      if (n != 30 || tmo_err !== 1'b0 || busy !== 1'b1) begin
         n_miss++;
         $display("FAIL tmo_wait: arm cycles=%0d tmo_err=%b busy=%b expected 30 0 1", n, tmo_err, busy);
      end
      n_vec++;
      if (pkt_count !== 16'd0) begin
         n_miss++;
         $display("FAIL tmo_count: pkt_count=%0d expected 0", pkt_count);
      end
`endif
   endtask

   task automatic test_reset_mid_packet();
      int b0, p0;
      bit ok;
      do_reset();
      b0 = rx_q.size(); p0 = pops;
      pkt_len = 16'd16;
      push_word(16'h0500);
      usb_di_ready = 1'b1;
      enable       = 1'b1;
      wait_rx(b0 + 3, 20, ok);
      reset_n = 1'b0;
      tick(1);
      n_vec++;
      if ({busy, usb_di_valid, pktend_arm, fifo_rden, tmo_err} !== 5'b0 ||
          usb_di !== 16'd0 || pkt_count !== 16'd0 || !ok) begin
         n_miss++;
         $display("FAIL rst_mid: ctl=%b usb_di=%0h pkt_count=%0d expected 00000 0 0",
                  {busy, usb_di_valid, pktend_arm, fifo_rden, tmo_err}, usb_di, pkt_count);
      end
      reset_n = 1'b1;
      push_word(16'h0600);
      wait_rx(b0 + 11, 30, ok);
      tick(2);
      n_vec++;
      if (!ok || rx_q.size() - b0 != 11 || pops - p0 != 2) begin
         n_miss++;
         $display("FAIL rst_next_count: words=%0d pops=%0d expected 11 2", rx_q.size() - b0, pops - p0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (rx_q[b0+3+i] !== 16'h0600 + 16'(i)) begin
               n_miss++;
               $display("FAIL rst_next_word%0d: got %0h expected %0h", i, rx_q[b0+3+i], 16'h0600 + 16'(i));
            end
         end
      end
      n_vec++;
      if (pkt_count !== 16'd0) begin
         n_miss++;
         $display("FAIL rst_next_pkts: pkt_count=%0d expected 0", pkt_count);
      end
      enable = 1'b0;
      tick(3);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_split_packet();
      test_backpressure();
      test_pause();
      test_timeout();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1, "global timeout");
   end

endmodule
